// File: rtl/col_parity_check_pkg.sv
// Shared constants, FSM encoding and small helpers for the column-parity checker.
// The data block is 5x5, row-major: column c is bits {c, c+5, c+10, c+15, c+20}.
package col_parity_check_pkg;

   localparam int NUM_COLS = 5;
   localparam int DATA_W   = 25;
   localparam int CNT_W    = 3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef logic [NUM_COLS-1:0] colVec_t;

   // Out-of-range column indices (5..7 on a 3-bit counter) read as zero.
   function automatic logic selBit(input colVec_t vec, input logic [CNT_W-1:0] idx);
      logic bitVal;
      bitVal = 1'b0;
      for (int i = 0; i < NUM_COLS; i++) begin
         if (idx == CNT_W'(i)) begin
            bitVal = vec[i];
         end
      end
      return bitVal;
   endfunction

endpackage

// File: rtl/col_parity_check_if.sv
// Request/result bundle between a block producer/consumer and the checker.
// The producer side is the master; the checker is the slave.
interface col_parity_check_if;
   import col_parity_check_pkg::*;

   logic                start;
   logic [DATA_W-1:0]   dataIn;
   logic [NUM_COLS-1:0] parIn;
   logic                ack;
   logic                busy;
   logic                done;
   logic [NUM_COLS-1:0] syndrome;
   logic                errFlag;
   logic [CNT_W-1:0]    errCnt;

   modport master (
      output start, dataIn, parIn, ack,
      input  busy, done, syndrome, errFlag, errCnt
   );

   modport slave (
      input  start, dataIn, parIn, ack,
      output busy, done, syndrome, errFlag, errCnt
   );

endinterface

// File: rtl/col_parity_check_col_select.sv
// Combinational selector: returns the five bits of column col from the latched block,
// bit r of the result being row r of that column.
module col_select
   import col_parity_check_pkg::*;
(
   input  logic [DATA_W-1:0]   dataBlock,
   input  logic [CNT_W-1:0]    col,
   output logic [NUM_COLS-1:0] colBits
);

   generate
      for (genvar gi = 0; gi < NUM_COLS; gi++) begin : gRow
         colVec_t rowBits;
         assign rowBits     = dataBlock[gi*NUM_COLS +: NUM_COLS];
         assign colBits[gi] = selBit(rowBits, col);
      end
   endgenerate

endmodule

// File: rtl/col_parity_check.sv
// Serial column-parity checker: latches a 5x5 block, walks its columns one per clock,
// and builds a syndrome plus mismatch count held until the consumer acknowledges.
module col_parity_check
   import col_parity_check_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   col_parity_check_if.slave bus
);

   logic [1:0]          stateReg;
   logic [1:0]          stateNext;
   logic [DATA_W-1:0]   dataReg;
   colVec_t             parReg;
   colVec_t             synReg;
   logic [CNT_W-1:0]    colReg;
   logic [CNT_W-1:0]    errCntReg;

   colVec_t             colBits;
   logic                serialBit;
   logic                accept;
   logic                step;
   logic                colLast;

   col_select uColSelect (
      .dataBlock (dataReg),
      .col       (colReg),
      .colBits   (colBits)
   );

   assign accept    = (stateReg == IDLE) && bus.start;
   assign step      = (stateReg == CALC);
   assign colLast   = (colReg == CNT_W'(NUM_COLS - 1));
   assign serialBit = (^colBits) ^ selBit(parReg, colReg);

   // ack is only looked at in DONE, so a simultaneous start there is dropped.
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (bus.start) stateNext = CALC;
         CALC:    if (colLast)   stateNext = DONE;
         DONE:    if (bus.ack)   stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Input capture: later changes on dataIn/parIn cannot reach the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         dataReg <= '0;
         parReg  <= '0;
      end else if (accept) begin
         dataReg <= bus.dataIn;
         parReg  <= bus.parIn;
      end
   end

   // Column counter, modulo NUM_COLS.
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         colReg <= '0;
      end else if (step) begin
         colReg <= colLast ? '0 : colReg + 1'b1;
      end
   end

   // Syndrome shift register: new bit enters at the top, so after five
   // shifts column c ends up in bit c.
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         synReg <= '0;
      end else if (step) begin
         synReg <= {serialBit, synReg[NUM_COLS-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst || accept) begin
         errCntReg <= '0;
      end else if (step && serialBit && (errCntReg < CNT_W'(NUM_COLS))) begin
         errCntReg <= errCntReg + 1'b1;
      end
   end

   assign bus.busy     = (stateReg != IDLE);
   assign bus.done     = (stateReg == DONE);
   assign bus.syndrome = synReg;
   assign bus.errCnt   = errCntReg;
   assign bus.errFlag  = (stateReg == DONE) && (|synReg);

endmodule

// File: doc/col_parity_check.md
COL_PARITY_CHECK -- requirements
Module: col_parity_check

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have port start  in  1  request to check one block, sampled only in IDLE.
REQ-003 SHALL have port dataIn  in  25  5x5 data block; column c = bits {c, c+5, c+10, c+15, c+20}.
REQ-004 SHALL have port parIn  in  5  received column parities; parIn[c] = even-parity bit of column c.
REQ-005 SHALL have port ack  in  1  consumer acknowledge of result, sampled only in DONE.
REQ-006 SHALL have port busy  out  1  high in CALC and DONE.
REQ-007 SHALL have port done  out  1  high only in DONE; result valid.
REQ-008 SHALL have port syndrome  out  5  syndrome[c] = parIn[c] XOR (XOR of column c).
REQ-009 SHALL have port errFlag  out  1  OR of syndrome, qualified by done.
REQ-010 SHALL have port errCnt  out  3  number of mismatching columns, 0..5.

Function
REQ-011 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-012 IDLE: when start=1 at edge E, SHALL latch dataIn and parIn, clear the 3-bit column counter, syndrome and errCnt, and enter CALC.
REQ-013 CALC: at edges E+1..E+5 SHALL process columns 0,1,2,3,4 in order, one per edge.
REQ-014 Per column: SHALL shift the syndrome register right one bit, with serial input at bit 4 equal to parity(column c) XOR latched parIn[c]; after five shifts, bit c holds column c.
REQ-015 Per column: SHALL increment errCnt when the serial bit is 1; errCnt SHALL never exceed 5 and SHALL NOT wrap.
REQ-016 Column counter SHALL count mod 5; its terminal count (c=4) SHALL move the FSM to DONE at edge E+5, so done=1 in the cycle after edge E+5.
REQ-017 DONE: done, syndrome, errFlag and errCnt SHALL hold stable until ack=1 is sampled; then SHALL return to IDLE on that edge. Outputs SHALL keep their values in IDLE until the next accepted start.
REQ-018 start in CALC or DONE SHALL be ignored. ack outside DONE SHALL be ignored.
REQ-019 When start and ack are both high in DONE, ack SHALL win. The block SHALL go to IDLE, and start SHALL be re-sampled only from the next cycle.
REQ-020 Changes to dataIn/parIn after acceptance SHALL NOT affect the result.
REQ-021 errFlag SHALL be 0 whenever done=0.

Reset
REQ-022 rst=1 at any edge, including mid-CALC or in DONE, SHALL force IDLE, counter=0, syndrome=0, errCnt=0, busy=0, done=0, errFlag=0, and the latched data/parity to 0.
REQ-023 rst SHALL take priority over start and ack in the same cycle.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (IDLE, CALC, DONE) and constants NUM_COLS=5, DATA_W=25, CNT_W=3.
REQ-025 A single sub-module col_select SHALL be used: combinational selector returning the 5 bits of column c from the latched block.
REQ-026 The counter and the syndrome shift register SHALL be reused from the existing counter mod-N and shift-register blocks.

Verification
REQ-027 Reset: hold rst 2 cycles, then release -> busy=0, done=0, syndrome=5'b00000, errCnt=0, errFlag=0.
REQ-028 Single-bit column hit: dataIn=25'h0000001, parIn=5'b00001 -> done exactly after edge E+5, syndrome=00000, errCnt=0, errFlag=0. Same dataIn with parIn=5'b00000 -> syndrome=00001, errCnt=1, errFlag=1.
REQ-029 All-columns hit: dataIn=25'h1FFFFFF, parIn=5'b00000 -> syndrome=11111, errCnt=5.
REQ-030 Column ordering: dataIn=25'h0100000 (bit 20, column 0) with parIn=5'b10000 -> syndrome=10001, errCnt=2.
REQ-031 Abort and ignore: assert rst at edge E+3 -> IDLE with all outputs 0 the next cycle; a separate run with start pulsed during CALC -> result unchanged, no second run.
REQ-032 Handshake: hold ack=0 for 10 cycles in DONE -> outputs stable. Then ack=1 with start=1 -> IDLE and no new acceptance. Then start next cycle -> accepted.
